// File: rtl/matrix_selector_pkg.sv
// Shared definitions for the matrix_selector operand feeder.
// Holds the element/matrix types, the step-counter limits and the four
// constant (A, B) matrix pairs that the feeder can stream.
package matrix_selector_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 3;

  // Step counter: steps 0..4 carry data, 5 is the saturating done state.
  localparam logic [2:0] T_DONE = 3'd5;

  typedef logic [DATA_W-1:0] elem_t;

  // Ascending ranges, so assignment patterns read row-major: [row][col].
  typedef elem_t [0:N-1][0:N-1] mat_t;

  typedef enum logic {
    MAT_ID_A = 1'b0,
    MAT_ID_B = 1'b1
  } mat_id_e;

  localparam mat_t MAT_A [0:3] = '{
    '{'{ 1,  2,  3}, '{ 4,  5,  6}, '{ 7,  8,  9}},
    '{'{ 1,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  1}},
    '{'{ 2,  2,  2}, '{ 2,  2,  2}, '{ 2,  2,  2}},
    '{'{10, 20, 30}, '{40, 50, 60}, '{70, 80, 90}}
  };

  localparam mat_t MAT_B [0:3] = '{
    '{'{ 9,  8,  7}, '{ 6,  5,  4}, '{ 3,  2,  1}},
    '{'{ 1,  2,  3}, '{ 4,  5,  6}, '{ 7,  8,  9}},
    '{'{ 3,  3,  3}, '{ 3,  3,  3}, '{ 3,  3,  3}},
    '{'{ 1,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  1}}
  };

endpackage

// File: rtl/matrix_rom.sv
// Combinational lookup into the constant matrix storage.
// Ports:
//   sel   - matrix-pair index 0..3
//   row   - element row 0..N-1 (out-of-range yields 0)
//   col   - element column 0..N-1 (out-of-range yields 0)
//   which - MAT_ID_A or MAT_ID_B
//   elem  - selected element
module matrix_rom
  import matrix_selector_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  input  mat_id_e           which,
  output logic [DATA_W-1:0] elem
);

  always_comb begin
    elem = '0;
    if ((row < 2'(N)) && (col < 2'(N))) begin
      if (which == MAT_ID_A) elem = MAT_A[sel][row][col];
      else                   elem = MAT_B[sel][row][col];
    end
  end

endmodule

// File: rtl/matrix_selector.sv
// Operand feeder for a 3x3 output-stationary systolic array.
// Streams the selected (A, B) pair with diagonal skew: row i of A on the
// west edge (a<i>_out) and column j of B on the north edge (b<j>_out),
// one step per clock over five clocks, then drives zeros until restarted
// by reset or by a change of select.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset
//   select - matrix-pair index 0..3
//   a0_out..a2_out - west-edge feeds (rows 0..2 of A), registered
//   b0_out..b2_out - north-edge feeds (columns 0..2 of B), registered
module matrix_selector
  import matrix_selector_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        select,
  output logic [DATA_W-1:0] a0_out,
  output logic [DATA_W-1:0] a1_out,
  output logic [DATA_W-1:0] a2_out,
  output logic [DATA_W-1:0] b0_out,
  output logic [DATA_W-1:0] b1_out,
  output logic [DATA_W-1:0] b2_out
);

  logic [2:0]        t;
  logic [1:0]        sel_q;

  logic [2:0]        a_off [N];
  logic [2:0]        b_off [N];
  logic [N-1:0]      a_vld;
  logic [N-1:0]      b_vld;
  logic [DATA_W-1:0] a_elem [N];
  logic [DATA_W-1:0] b_elem [N];
  logic [DATA_W-1:0] a_p1 [N];
  logic [DATA_W-1:0] b_p1 [N];

  // Skew: lane i is delayed by i steps, so it carries element (t - i).
  // When t < i the subtraction wraps, which the t >= i term rejects.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign a_off[i] = t - 3'(i);
    assign b_off[i] = t - 3'(i);
    assign a_vld[i] = (t >= 3'(i)) && (a_off[i] <= 3'(N - 1));
    assign b_vld[i] = (t >= 3'(i)) && (b_off[i] <= 3'(N - 1));

    matrix_rom u_rom_a (
      .sel   (sel_q),
      .row   (2'(i)),
      .col   (a_off[i][1:0]),
      .which (MAT_ID_A),
      .elem  (a_elem[i])
    );

    matrix_rom u_rom_b (
      .sel   (sel_q),
      .row   (b_off[i][1:0]),
      .col   (2'(i)),
      .which (MAT_ID_B),
      .elem  (b_elem[i])
    );
  end

  // Stage p1: registered edge feeds. Reset beats a select change, which
  // beats normal streaming; a select change costs one zero cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      t     <= '0;
      sel_q <= select;
      for (int i = 0; i < N; i++) begin
        a_p1[i] <= '0;
        b_p1[i] <= '0;
      end
    end else if (select != sel_q) begin
      t     <= '0;
      sel_q <= select;
      for (int i = 0; i < N; i++) begin
        a_p1[i] <= '0;
        b_p1[i] <= '0;
      end
    end else if (t < T_DONE) begin
      t <= t + 3'd1;
      for (int i = 0; i < N; i++) begin
        a_p1[i] <= a_vld[i] ? a_elem[i] : '0;
        b_p1[i] <= b_vld[i] ? b_elem[i] : '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_p1[i] <= '0;
        b_p1[i] <= '0;
      end
    end
  end

  assign a0_out = a_p1[0];
  assign a1_out = a_p1[1];
  assign a2_out = a_p1[2];
  assign b0_out = b_p1[0];
  assign b1_out = b_p1[1];
  assign b2_out = b_p1[2];

endmodule

// File: tb/tb_matrix_selector.sv
// Directed self-checking bench for matrix_selector.
module tb_matrix_selector;

  logic        clk;
  logic        reset;
  logic [1:0]  select;
  logic [31:0] a0_out, a1_out, a2_out, b0_out, b1_out, b2_out;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_a, cnt_b;

  matrix_selector dut (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .a0_out (a0_out),
    .a1_out (a1_out),
    .a2_out (a2_out),
    .b0_out (b0_out),
    .b1_out (b1_out),
    .b2_out (b2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag,
                      input logic [31:0] ea0, input logic [31:0] ea1, input logic [31:0] ea2,
                      input logic [31:0] eb0, input logic [31:0] eb1, input logic [31:0] eb2);
    chk({tag, ".a0"}, a0_out, ea0);
    chk({tag, ".a1"}, a1_out, ea1);
    chk({tag, ".a2"}, a2_out, ea2);
    chk({tag, ".b0"}, b0_out, eb0);
    chk({tag, ".b1"}, b1_out, eb1);
    chk({tag, ".b2"}, b2_out, eb2);
  endtask

  // Hold reset for n edges (checking zeros), then release.
  task automatic do_reset(input string tag, input logic [1:0] s, input int n);
    reset  = 1'b0;
    select = s;
    for (int k = 0; k < n; k++) begin
      step();
      chk6(tag, 0, 0, 0, 0, 0, 0);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    select = 2'd0;
    #2;

    // 1: sel0 full stream, then done holds zero
    do_reset("t1.rst", 2'd0, 2);
    step(); chk6("t1.e1", 1, 0, 0, 9, 0, 0);
    step(); chk6("t1.e2", 2, 4, 0, 6, 8, 0);
    step(); chk6("t1.e3", 3, 5, 7, 3, 5, 7);
    step(); chk6("t1.e4", 0, 6, 8, 0, 2, 4);
    step(); chk6("t1.e5", 0, 0, 9, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      step(); chk6("t1.done", 0, 0, 0, 0, 0, 0);
    end

    // 2: sel2, each element appears exactly once
    do_reset("t2.rst", 2'd2, 1);
    cnt_a = 0;
    cnt_b = 0;
    for (int e = 1; e <= 7; e++) begin
      step();
      cnt_a += int'(a0_out != 0) + int'(a1_out != 0) + int'(a2_out != 0);
      cnt_b += int'(b0_out != 0) + int'(b1_out != 0) + int'(b2_out != 0);
      if (e == 3) chk6("t2.e3", 2, 2, 2, 3, 3, 3);
      if (e == 4) chk6("t2.e4", 0, 2, 2, 0, 3, 3);
    end
    chk("t2.cnt_a", 32'(cnt_a), 32'd9);
    chk("t2.cnt_b", 32'(cnt_b), 32'd9);

    // 3: sel3, B is identity
    do_reset("t3.rst", 2'd3, 1);
    step(); chk6("t3.e1", 10,  0,  0, 1, 0, 0);
    step(); chk6("t3.e2", 20, 40,  0, 0, 0, 0);
    step(); chk6("t3.e3", 30, 50, 70, 0, 1, 0);
    step(); chk6("t3.e4",  0, 60, 80, 0, 0, 0);
    step(); chk6("t3.e5",  0,  0, 90, 0, 0, 1);

    // 4: mid-stream select change 0 -> 1
    do_reset("t4.rst", 2'd0, 1);
    step(); chk6("t4.e1", 1, 0, 0, 9, 0, 0);
    step(); chk6("t4.e2", 2, 4, 0, 6, 8, 0);
    select = 2'd1;
    step(); chk6("t4.chg", 0, 0, 0, 0, 0, 0);
    step(); chk6("t4.n1", 1, 0, 0, 1, 0, 0);
    step(); chk6("t4.n2", 0, 0, 0, 4, 2, 0);

    // 5: reset at e3 aborts; reset beats a simultaneous select change
    do_reset("t5.rst", 2'd0, 1);
    step(); chk6("t5.e1", 1, 0, 0, 9, 0, 0);
    step(); chk6("t5.e2", 2, 4, 0, 6, 8, 0);
    reset = 1'b0;
    step(); chk6("t5.abort", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); chk6("t5.r1", 1, 0, 0, 9, 0, 0);
    step(); chk6("t5.r2", 2, 4, 0, 6, 8, 0);
    reset  = 1'b0;
    select = 2'd2;
    step(); chk6("t5.prio", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); chk6("t5.p1", 2, 0, 0, 3, 0, 0);
    step(); chk6("t5.p2", 2, 2, 0, 3, 3, 0);

    // 6: restart from done, then mid-stream toggle back
    do_reset("t6.rst", 2'd0, 1);
    for (int k = 0; k < 7; k++) step();
    chk6("t6.done", 0, 0, 0, 0, 0, 0);
    select = 2'd1;
    step(); chk6("t6.chg1", 0, 0, 0, 0, 0, 0);
    step(); chk6("t6.s1e1", 1, 0, 0, 1, 0, 0);
    step(); chk6("t6.s1e2", 0, 0, 0, 4, 2, 0);
    select = 2'd0;
    step(); chk6("t6.chg0", 0, 0, 0, 0, 0, 0);
    step(); chk6("t6.s0e1", 1, 0, 0, 9, 0, 0);
    step(); chk6("t6.s0e2", 2, 4, 0, 6, 8, 0);
    step(); chk6("t6.s0e3", 3, 5, 7, 3, 5, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
